// File: rtl/decode_pkg.sv
// Shared types and default sizing for the decode_scan block.
package decode_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        SCAN = 2'd2
    } state_t;

    localparam int DEF_N     = 3;
    localparam int DEF_DWELL = 4;

endpackage

// File: rtl/dwell_timer.sv
// Counts cycles spent on one scan index; o_wrap marks the last cycle of a dwell.
module dwell_timer
    import decode_pkg::*;
#(
    parameter int DWELL = DEF_DWELL
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_wrap
);

    localparam int            CW   = $clog2(DWELL) + 1;
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0] r_cnt;

    // A clear in the same cycle wins, so a fresh index never wraps early.
    assign o_wrap = i_run && !i_clear && (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/decode_scan.sv
// One-hot decoder with a direct-hold mode and a single-revolution scan mode.
module decode_scan
    import decode_pkg::*;
#(
    parameter  int N     = DEF_N,
    parameter  int DWELL = DEF_DWELL,
    localparam int OUT_W = 2 ** N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     sel,
    input  logic             mode,
    output logic [OUT_W-1:0] y,
    output logic             y_valid,
    output logic             busy
);

    localparam logic [OUT_W-1:0] ONE       = OUT_W'(1);
    localparam logic [N:0]       LAST_STEP = (N + 1)'(OUT_W - 1);

    state_t           r_state;
    logic [OUT_W-1:0] r_y;
    logic             r_vld;
    logic             r_busy;
    logic [N-1:0]     r_idx;
    logic [N:0]       r_step;

    logic             w_accept;
    logic             w_wrap;
    logic [N-1:0]     w_idx_nxt;

    assign in_ready  = (r_state != SCAN);
    assign w_accept  = in_valid && in_ready && en;
    assign w_idx_nxt = r_idx + 1'b1;

    assign y       = r_y;
    assign y_valid = r_vld;
    assign busy    = r_busy;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .i_clear (!en || w_accept),
        .i_run   (r_state == SCAN),
        .o_wrap  (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
            r_idx   <= '0;
            r_step  <= '0;
        end else if (!en) begin
            r_state <= IDLE;
            r_y     <= '0;
            r_vld   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, HOLD: begin
                    if (w_accept) begin
                        r_y     <= ONE << sel;
                        r_vld   <= 1'b1;
                        r_idx   <= sel;
                        r_step  <= '0;
                        r_busy  <= mode;
                        r_state <= mode ? SCAN : HOLD;
                    end
                end
                SCAN: begin
                    // r_step counts indices already shown; the last one ends the revolution.
                    if (w_wrap) begin
                        if (r_step == LAST_STEP) begin
                            r_state <= IDLE;
                            r_y     <= '0;
                            r_vld   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_idx  <= w_idx_nxt;
                            r_y    <= ONE << w_idx_nxt;
                            r_step <= r_step + 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_y     <= '0;
                    r_vld   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_scan.sv
// Self-checking bench: three decode_scan configurations against a timeline-based model.
module tb_decode_scan;

    logic       clk;
    logic       rst;
    logic       en_v   [3];
    logic       vld_v  [3];
    logic       mode_v [3];
    logic [2:0] sel_v  [3];

    logic [7:0] y0, y2;
    logic [1:0] y1;
    logic       yv_v [3];
    logic       bz_v [3];
    logic       rd_v [3];

    int total = 0;
    int bad   = 0;
    bit chk_on = 0;

    // Model: per DUT, what was accepted last and how many edges ago.
    int mn    [3] = '{3, 1, 3};
    int md    [3] = '{2, 1, 4};
    int kind  [3];   // 0 off, 1 direct hold, 2 scanning
    int msel  [3];
    int mel   [3];

    logic [7:0] scan_seq [8] = '{8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20};

    decode_scan #(.N(3), .DWELL(2)) u0 (
        .clk(clk), .rst(rst), .en(en_v[0]), .in_valid(vld_v[0]), .in_ready(rd_v[0]),
        .sel(sel_v[0]), .mode(mode_v[0]), .y(y0), .y_valid(yv_v[0]), .busy(bz_v[0])
    );
    decode_scan #(.N(1), .DWELL(1)) u1 (
        .clk(clk), .rst(rst), .en(en_v[1]), .in_valid(vld_v[1]), .in_ready(rd_v[1]),
        .sel(sel_v[1][0:0]), .mode(mode_v[1]), .y(y1), .y_valid(yv_v[1]), .busy(bz_v[1])
    );
    decode_scan #(.N(3), .DWELL(4)) u2 (
        .clk(clk), .rst(rst), .en(en_v[2]), .in_valid(vld_v[2]), .in_ready(rd_v[2]),
        .sel(sel_v[2]), .mode(mode_v[2]), .y(y2), .y_valid(yv_v[2]), .busy(bz_v[2])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] get_y(int i);
        if (i == 0) return y0;
        if (i == 1) return {6'b0, y1};
        return y2;
    endfunction

    function automatic logic [7:0] exp_y(int i);
        int w;
        w = 1 << mn[i];
        if (kind[i] == 1) return 8'(1) << msel[i];
        if (kind[i] == 2) return 8'(1) << ((msel[i] + mel[i] / md[i]) % w);
        return 8'h00;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            bit rdy;
            rdy = (kind[i] != 2);
            if (rst || !en_v[i]) begin
                kind[i] = 0;
            end else if (rdy && vld_v[i]) begin
                kind[i] = mode_v[i] ? 2 : 1;
                msel[i] = int'(sel_v[i]) & ((1 << mn[i]) - 1);
                mel[i]  = 0;
            end else if (kind[i] == 2) begin
                mel[i]++;
                if (mel[i] == (1 << mn[i]) * md[i]) kind[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                logic [7:0] e;
                e = exp_y(i);
                chk($sformatf("model_y%0d", i), 32'(get_y(i)), 32'(e));
                chk($sformatf("model_yvalid%0d", i), 32'(yv_v[i]), 32'(e != 0));
                chk($sformatf("model_busy%0d", i), 32'(bz_v[i]), 32'(kind[i] == 2));
                chk($sformatf("model_ready%0d", i), 32'(rd_v[i]), 32'(kind[i] != 2));
            end
        end
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            kind[i] = 0; msel[i] = 0; mel[i] = 0;
            en_v[i] = 1'b1; vld_v[i] = 1'b1; mode_v[i] = 1'b0; sel_v[i] = 3'd0;
        end
        rst = 1'b1;

        // Reset with in_valid held high
        tick();
        chk_on = 1;
        chk("rst_y_c1", 32'(y0), 32'h0);
        tick();
        chk("rst_y_c2", 32'(y0), 32'h0);
        chk("rst_yvalid", 32'(yv_v[0]), 32'h0);
        chk("rst_busy", 32'(bz_v[0]), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) vld_v[i] = 1'b0;
        chk("rst_ready", 32'(rd_v[0]), 32'h1);

        // Direct decode, then replacement without a gap
        vld_v[0] = 1'b1; sel_v[0] = 3'd5; mode_v[0] = 1'b0;
        tick();
        chk("direct_sel5", 32'(y0), 32'h20);
        chk("direct_valid", 32'(yv_v[0]), 32'h1);
        vld_v[0] = 1'b0;
        tick();
        chk("direct_hold", 32'(y0), 32'h20);
        vld_v[0] = 1'b1; sel_v[0] = 3'd0;
        tick();
        chk("direct_sel0", 32'(y0), 32'h01);

        // Scan from 6 with wrap; in_valid kept high with sel=2 as back-pressure
        sel_v[0] = 3'd6; mode_v[0] = 1'b1;
        tick();
        sel_v[0] = 3'd2; mode_v[0] = 1'b0;
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("scan_y_%0d", k), 32'(y0), 32'(scan_seq[k / 2]));
            chk($sformatf("scan_ready_%0d", k), 32'(rd_v[0]), 32'h0);
            tick();
        end
        vld_v[0] = 1'b0;
        chk("scan_end_y", 32'(y0), 32'h0);
        chk("scan_end_busy", 32'(bz_v[0]), 32'h0);

        // Abort by dropping en; valid with en low is not an accept
        vld_v[0] = 1'b1; sel_v[0] = 3'd1; mode_v[0] = 1'b1;
        tick();
        vld_v[0] = 1'b0;
        tick();
        tick();
        chk("abort_pre_busy", 32'(bz_v[0]), 32'h1);
        en_v[0] = 1'b0; vld_v[0] = 1'b1;
        tick();
        chk("abort_y", 32'(y0), 32'h0);
        chk("abort_busy", 32'(bz_v[0]), 32'h0);
        tick();
        chk("en0_no_accept", 32'(y0), 32'h0);
        en_v[0] = 1'b1; vld_v[0] = 1'b0;
        tick();

        // Reset mid-scan
        vld_v[0] = 1'b1; sel_v[0] = 3'd3; mode_v[0] = 1'b1;
        tick();
        vld_v[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rstmid_y", 32'(y0), 32'h0);
        chk("rstmid_busy", 32'(bz_v[0]), 32'h0);
        rst = 1'b0;
        chk("rstmid_ready", 32'(rd_v[0]), 32'h1);

        // N=1, DWELL=1 corner
        vld_v[1] = 1'b1; sel_v[1] = 3'd1; mode_v[1] = 1'b1;
        tick();
        vld_v[1] = 1'b0;
        chk("n1_first", 32'(y1), 32'h2);
        tick();
        chk("n1_second", 32'(y1), 32'h1);
        tick();
        chk("n1_done", 32'(y1), 32'h0);
        tick();

        // Randomized traffic on all three instances
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                en_v[i]   = ($urandom % 16) != 0;
                vld_v[i]  = ($urandom % 3) == 0;
                mode_v[i] = $urandom % 2;
                sel_v[i]  = 3'($urandom % 8);
            end
            rst = ($urandom % 250) == 0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
